// File: rtl/baccarat_round_fsm.sv
// Baccarat round controller: sequences the six card-load strobes, applies the
// tableau third-card rules and drives the win lights and round_done flag.
module baccarat_round_fsm #(
    parameter int unsigned NATURAL_MIN     = 8,
    parameter int unsigned PLAYER_DRAW_MAX = 5
) (
    input  logic       slow_clock,
    input  logic       resetb,
    input  logic       step,
    input  logic [3:0] pscore,
    input  logic [3:0] dscore,
    input  logic [3:0] pcard3,
    output logic       load_pcard1,
    output logic       load_pcard2,
    output logic       load_pcard3,
    output logic       load_dcard1,
    output logic       load_dcard2,
    output logic       load_dcard3,
    output logic       player_win_light,
    output logic       dealer_win_light,
    output logic       round_done
);

    localparam logic [3:0] NAT_MIN  = 4'(NATURAL_MIN);
    localparam logic [3:0] PDRAW_MX = 4'(PLAYER_DRAW_MAX);

    typedef enum logic [3:0] {
        DEAL_P1  = 4'd0,
        DEAL_D1  = 4'd1,
        DEAL_P2  = 4'd2,
        DEAL_D2  = 4'd3,
        EVAL     = 4'd4,
        DEAL_P3  = 4'd5,
        BANK_DEC = 4'd6,
        DEAL_D3  = 4'd7,
        RESULT   = 4'd8
    } state_e;

    state_e state_q;
    state_e state_d;

    // Banker tableau once the player's third card is known; face cards count as 0.
    function automatic logic banker_draws(input logic [3:0] ds, input logic [3:0] p3);
        logic [3:0] v;
        logic       draw;
        v = (p3 > 4'd9) ? 4'd0 : p3;
        case (ds)
            4'd0, 4'd1, 4'd2: draw = 1'b1;
            4'd3:             draw = (v != 4'd8);
            4'd4:             draw = (v >= 4'd2) && (v <= 4'd7);
            4'd5:             draw = (v >= 4'd4) && (v <= 4'd7);
            4'd6:             draw = (v >= 4'd6) && (v <= 4'd7);
            default:          draw = 1'b0;
        endcase
        return draw;
    endfunction

    // Two-card evaluation: natural, player draw, player stands / banker decision.
    function automatic state_e eval_next(input logic [3:0] ps, input logic [3:0] ds);
        state_e nxt;
        if ((ps >= NAT_MIN) || (ds >= NAT_MIN)) begin
            nxt = RESULT;
        end else if (ps <= PDRAW_MX) begin
            nxt = DEAL_P3;
        end else if (ds <= 4'd5) begin
            nxt = DEAL_D3;
        end else begin
            nxt = RESULT;
        end
        return nxt;
    endfunction

    // State register; reset wins over everything, including mid-round.
    always_ff @(posedge slow_clock) begin
        if (!resetb) begin
            state_q <= DEAL_P1;
        end else begin
            state_q <= state_d;
        end
    end

    // Next state: advance only on step, RESULT is terminal, bad encodings recover.
    always_comb begin
        state_d = state_q;
        case (state_q)
            DEAL_P1:  if (step) state_d = DEAL_D1;
            DEAL_D1:  if (step) state_d = DEAL_P2;
            DEAL_P2:  if (step) state_d = DEAL_D2;
            DEAL_D2:  if (step) state_d = EVAL;
            EVAL:     if (step) state_d = eval_next(pscore, dscore);
            DEAL_P3:  if (step) state_d = BANK_DEC;
            BANK_DEC: if (step) state_d = banker_draws(dscore, pcard3) ? DEAL_D3 : RESULT;
            DEAL_D3:  if (step) state_d = RESULT;
            RESULT:   state_d = RESULT;
            default:  state_d = DEAL_P1;
        endcase
    end

    // Outputs: strobes fire on the leaving edge only (masked while in reset so no
    // card register captures during reset); lights compare scores in RESULT.
    always_comb begin
        load_pcard1      = 1'b0;
        load_pcard2      = 1'b0;
        load_pcard3      = 1'b0;
        load_dcard1      = 1'b0;
        load_dcard2      = 1'b0;
        load_dcard3      = 1'b0;
        player_win_light = 1'b0;
        dealer_win_light = 1'b0;
        round_done       = 1'b0;
        case (state_q)
            DEAL_P1: load_pcard1 = step & resetb;
            DEAL_D1: load_dcard1 = step & resetb;
            DEAL_P2: load_pcard2 = step & resetb;
            DEAL_D2: load_dcard2 = step & resetb;
            DEAL_P3: load_pcard3 = step & resetb;
            DEAL_D3: load_dcard3 = step & resetb;
            RESULT: begin
                round_done       = 1'b1;
                player_win_light = (pscore >= dscore);
                dealer_win_light = (dscore >= pscore);
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_baccarat_round_fsm.sv
// Directed bench for baccarat_round_fsm with an expected-output scoreboard.
module tb_baccarat_round_fsm;

    logic       clk;
    logic       resetb;
    logic       step;
    logic [3:0] pscore;
    logic [3:0] dscore;
    logic [3:0] pcard3;
    logic       load_pcard1, load_pcard2, load_pcard3;
    logic       load_dcard1, load_dcard2, load_dcard3;
    logic       player_win_light, dealer_win_light, round_done;

    int checks = 0;
    int errors = 0;

    // {p1, p2, p3, d1, d2, d3, player_light, dealer_light, round_done}
    localparam logic [8:0] E_NONE = 9'b000000000;
    localparam logic [8:0] E_P1   = 9'b100000000;
    localparam logic [8:0] E_P2   = 9'b010000000;
    localparam logic [8:0] E_P3   = 9'b001000000;
    localparam logic [8:0] E_D1   = 9'b000100000;
    localparam logic [8:0] E_D2   = 9'b000010000;
    localparam logic [8:0] E_D3   = 9'b000001000;
    localparam logic [8:0] E_PW   = 9'b000000101;
    localparam logic [8:0] E_DW   = 9'b000000011;
    localparam logic [8:0] E_TIE  = 9'b000000111;

    logic [8:0] exp_q[$];
    string      tag_q[$];

    baccarat_round_fsm #(.NATURAL_MIN(8), .PLAYER_DRAW_MAX(5)) dut (
        .slow_clock       (clk),
        .resetb           (resetb),
        .step             (step),
        .pscore           (pscore),
        .dscore           (dscore),
        .pcard3           (pcard3),
        .load_pcard1      (load_pcard1),
        .load_pcard2      (load_pcard2),
        .load_pcard3      (load_pcard3),
        .load_dcard1      (load_dcard1),
        .load_dcard2      (load_dcard2),
        .load_dcard3      (load_dcard3),
        .player_win_light (player_win_light),
        .dealer_win_light (dealer_win_light),
        .round_done       (round_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // One clock cycle: drive inputs after the falling edge, record the expected
    // outputs, compare before the next rising edge (which then consumes the inputs).
    task automatic cyc(input logic s, input logic rb, input logic [3:0] ps,
                       input logic [3:0] ds, input logic [3:0] p3,
                       input logic [8:0] exp, input string tag);
        logic [8:0] obs;
        logic [8:0] want;
        string      t;
        @(negedge clk);
        step   = s;
        resetb = rb;
        pscore = ps;
        dscore = ds;
        pcard3 = p3;
        exp_q.push_back(exp);
        tag_q.push_back(tag);
        #1;
        obs  = {load_pcard1, load_pcard2, load_pcard3, load_dcard1, load_dcard2,
                load_dcard3, player_win_light, dealer_win_light, round_done};
        want = exp_q.pop_front();
        t    = tag_q.pop_front();
        checks++;
        assert (obs === want) else begin
            errors++;
            $error("FAIL %s observed=%b expected=%b", t, obs, want);
        end
    endtask

    // Stepped deal of the four opening cards from DEAL_P1 up to EVAL.
    task automatic deal_four(input string pfx);
        cyc(1, 1, 0, 0, 0, E_P1, {pfx, "_p1"});
        cyc(1, 1, 0, 0, 0, E_D1, {pfx, "_d1"});
        cyc(1, 1, 0, 0, 0, E_P2, {pfx, "_p2"});
        cyc(1, 1, 0, 0, 0, E_D2, {pfx, "_d2"});
    endtask

    initial begin
        resetb = 1'b0;
        step   = 1'b0;
        pscore = 4'd0;
        dscore = 4'd0;
        pcard3 = 4'd0;
        repeat (2) @(posedge clk);

        // Natural: 8 vs 3 reaches RESULT after 5 stepped edges, player wins.
        deal_four("nat");
        cyc(1, 1, 8, 3, 0, E_NONE, "nat_eval");
        cyc(1, 1, 8, 3, 0, E_PW,   "nat_result");
        cyc(0, 1, 8, 3, 0, E_PW,   "nat_result_hold");

        // Reset from RESULT: two reset edges, then everything is quiet in DEAL_P1.
        cyc(0, 0, 8, 3, 0, E_PW,   "rst_from_result");
        cyc(0, 0, 8, 3, 0, E_NONE, "rst_second_edge");
        cyc(0, 1, 8, 3, 0, E_NONE, "rst_idle_p1");

        // Step gating in DEAL_D1, then player stands 7 vs 4 and banker draws to 9.
        cyc(1, 1, 0, 0, 0, E_P1, "gate_p1");
        for (int i = 0; i < 5; i++) cyc(0, 1, 0, 0, 0, E_NONE, "gate_hold");
        cyc(1, 1, 0, 0, 0, E_D1,   "gate_d1");
        cyc(1, 1, 0, 0, 0, E_P2,   "stand_p2");
        cyc(1, 1, 0, 0, 0, E_D2,   "stand_d2");
        cyc(1, 1, 7, 4, 0, E_NONE, "stand_eval");
        cyc(1, 1, 7, 4, 0, E_D3,   "stand_d3");
        cyc(1, 1, 7, 9, 0, E_DW,   "stand_result");
        cyc(0, 0, 7, 9, 0, E_DW,   "stand_rst");

        // Banker on 3 with player third card 8: banker stands, 3/3 tie.
        deal_four("b8");
        cyc(1, 1, 3, 3, 0, E_NONE, "b8_eval");
        cyc(1, 1, 3, 3, 0, E_P3,   "b8_p3");
        cyc(1, 1, 3, 3, 8, E_NONE, "b8_bank");
        cyc(1, 1, 3, 3, 8, E_TIE,  "b8_result");
        cyc(0, 0, 3, 3, 8, E_TIE,  "b8_rst");

        // Banker on 3 with a queen (value 0): banker draws, final 6/6 tie.
        deal_four("bq");
        cyc(1, 1, 3, 3, 0,  E_NONE, "bq_eval");
        cyc(1, 1, 3, 3, 0,  E_P3,   "bq_p3");
        cyc(1, 1, 3, 3, 12, E_NONE, "bq_bank");
        cyc(1, 1, 6, 3, 12, E_D3,   "bq_d3");
        cyc(0, 1, 6, 6, 12, E_TIE,  "bq_result");
        cyc(0, 0, 6, 6, 12, E_TIE,  "bq_rst");

        // Mid-round reset in DEAL_P3: no strobe, back in DEAL_P1 next edge.
        deal_four("mr");
        cyc(1, 1, 2, 5, 0, E_NONE, "mr_eval");
        cyc(1, 0, 2, 5, 0, E_NONE, "mr_p3_in_reset");
        cyc(1, 1, 2, 5, 0, E_P1,   "mr_back_p1");

        // Banker on 6 with player card 6 draws.
        cyc(1, 1, 0, 0, 0, E_D1,   "b6_d1");
        cyc(1, 1, 0, 0, 0, E_P2,   "b6_p2");
        cyc(1, 1, 0, 0, 0, E_D2,   "b6_d2");
        cyc(1, 1, 4, 6, 0, E_NONE, "b6_eval");
        cyc(1, 1, 4, 6, 0, E_P3,   "b6_p3");
        cyc(1, 1, 0, 6, 6, E_NONE, "b6_bank");
        cyc(1, 1, 0, 6, 6, E_D3,   "b6_d3");
        cyc(1, 1, 0, 8, 6, E_DW,   "b6_result");
        cyc(0, 0, 0, 8, 6, E_DW,   "b6_rst");

        // Banker on 7 never draws, even with player card 6.
        deal_four("b7");
        cyc(1, 1, 1, 7, 0, E_NONE, "b7_eval");
        cyc(1, 1, 1, 7, 0, E_P3,   "b7_p3");
        cyc(1, 1, 5, 7, 6, E_NONE, "b7_bank");
        cyc(1, 1, 5, 7, 6, E_DW,   "b7_result");
        cyc(0, 0, 5, 7, 6, E_DW,   "b7_rst");

        // Both stand on 6/6: straight to RESULT with both lights.
        deal_four("ss");
        cyc(1, 1, 6, 6, 0, E_NONE, "ss_eval");
        cyc(1, 1, 6, 6, 0, E_TIE,  "ss_result");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
